// File: rtl/ascon_pt_packer.sv
// Purpose : packs 32-bit big-endian plaintext words into 64-bit Ascon-128 rate blocks with end-of-message padding.
// Latency : blk_valid rises one cycle after the word transfer that completes a block; one block per 3 cycles at best.
// Backpress: in_ready drops while a block is presented; blk_* hold stable until blk_ready consumes the block.
//
// Optional feature macro: ASCON_PAD_EN. When defined, the 0x80 padding byte is inserted and an extra
// padding-only block is emitted after a message that ends on a block boundary. When undefined, unused
// bytes are zero, blk_pad stays 0 and a full final block is itself marked last.
//
// Ports:
//   clk, rst                  single clock, asynchronous active-high reset
//   in_data/in_valid/in_ready plaintext word stream (first message byte in [31:24])
//   in_last, in_bytes         final-word marker and its MSB-aligned valid byte count (0 or >4 means 4)
//   blk_data/blk_valid/blk_ready  rate block stream to the encrypt core
//   blk_last, blk_pad, blk_nbytes final-block marker, padding-present flag, message bytes in the block
module ascon_pt_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [2:0]  in_bytes,
    output logic        in_ready,
    output logic [63:0] blk_data,
    output logic        blk_valid,
    input  logic        blk_ready,
    output logic        blk_last,
    output logic        blk_pad,
    output logic [3:0]  blk_nbytes
);

`ifdef ASCON_PAD_EN
    localparam logic PAD_EN = 1'b1;
`else
    localparam logic PAD_EN = 1'b0;
`endif

    localparam logic [1:0] S_HI   = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam logic [1:0] S_XPAD = 2'd3;

    logic [1:0]  state;
    logic        pad_pending;
    logic        run;        // low during reset and until the first edge after release
    logic        in_xfer;
    logic        blk_xfer;
    logic [2:0]  nb;         // normalised byte count of a last word
    logic [31:0] tail;       // last word with bytes beyond nb masked, plus the pad byte

    assign in_ready  = run && (state == S_HI || state == S_LO);
    assign blk_valid = (state == S_OUT) || (state == S_XPAD);
    assign in_xfer   = in_valid && in_ready;
    assign blk_xfer  = blk_valid && blk_ready;

    always_comb begin
        nb = in_bytes;
        if (in_bytes == 3'd0 || in_bytes > 3'd4) begin
            nb = 3'd4;
        end
    end

    // Byte i (i=0 is [31:24]) keeps data below nb; byte nb carries 0x80 when padding is enabled.
    always_comb begin
        tail = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < nb) begin
                tail[31-8*i -: 8] = in_data[31-8*i -: 8];
            end else if (3'(i) == nb && PAD_EN) begin
                tail[31-8*i -: 8] = 8'h80;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_HI;
            run         <= 1'b0;
            pad_pending <= 1'b0;
            blk_data    <= 64'h0;
            blk_last    <= 1'b0;
            blk_pad     <= 1'b0;
            blk_nbytes  <= 4'd0;
        end else begin
            run <= 1'b1;
            case (state)
                S_HI: begin
                    if (in_xfer) begin
                        if (!in_last) begin
                            blk_data[63:32] <= in_data;
                            state           <= S_LO;
                        end else begin
                            // A full 4-byte last word pushes the pad byte into the lower word.
                            blk_data   <= {tail, (nb == 3'd4 && PAD_EN) ? 32'h8000_0000 : 32'h0};
                            blk_last   <= 1'b1;
                            blk_pad    <= PAD_EN;
                            blk_nbytes <= {1'b0, nb};
                            state      <= S_OUT;
                        end
                    end
                end
                S_LO: begin
                    if (in_xfer) begin
                        state <= S_OUT;
                        if (!in_last) begin
                            blk_data[31:0] <= in_data;
                            blk_last       <= 1'b0;
                            blk_pad        <= 1'b0;
                            blk_nbytes     <= 4'd8;
                        end else if (nb != 3'd4) begin
                            blk_data[31:0] <= tail;
                            blk_last       <= 1'b1;
                            blk_pad        <= PAD_EN;
                            blk_nbytes     <= 4'd4 + {1'b0, nb};
                        end else begin
                            // Message ends exactly on a block boundary: padding needs a block of its own.
                            blk_data[31:0] <= in_data;
                            blk_last       <= !PAD_EN;
                            blk_pad        <= 1'b0;
                            blk_nbytes     <= 4'd8;
                            pad_pending    <= PAD_EN;
                        end
                    end
                end
                S_OUT: begin
                    if (blk_xfer) begin
                        pad_pending <= 1'b0;
                        if (pad_pending) begin
                            blk_data   <= 64'h8000_0000_0000_0000;
                            blk_last   <= 1'b1;
                            blk_pad    <= 1'b1;
                            blk_nbytes <= 4'd0;
                            state      <= S_XPAD;
                        end else begin
                            state <= S_HI;
                        end
                    end
                end
                S_XPAD: begin
                    if (blk_xfer) begin
                        state <= S_HI;
                    end
                end
                default: state <= S_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_pt_packer.sv
`timescale 1ns/1ps
module tb_ascon_pt_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic [2:0]  in_bytes;
    logic        in_ready;
    logic [63:0] blk_data;
    logic        blk_valid;
    logic        blk_ready;
    logic        blk_last;
    logic        blk_pad;
    logic [3:0]  blk_nbytes;

`ifdef ASCON_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic        p;
        logic [3:0]  n;
    } blk_t;

    blk_t sb[$];
    int   checks = 0;
    int   passes = 0;

    ascon_pt_packer dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_bytes   (in_bytes),
        .in_ready   (in_ready),
        .blk_data   (blk_data),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_last   (blk_last),
        .blk_pad    (blk_pad),
        .blk_nbytes (blk_nbytes)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_blk(input logic [63:0] d, input logic l, input logic p, input logic [3:0] n);
        blk_t e;
        e = {d, l, p, n};
        sb.push_back(e);
    endtask

    // Presents a word at posedge+1 and holds it until accepted (bounded).
    task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] b);
        int n;
        n        = 0;
        in_data  = d;
        in_last  = l;
        in_bytes = b;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) begin
            checks++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || blk_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending_blocks", 128'(sb.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every consumed block against the scoreboard head.
    initial begin
        blk_t act;
        blk_t e;
        forever begin
            @(negedge clk);
            if (!rst && blk_valid && blk_ready) begin
                act = {blk_data, blk_last, blk_pad, blk_nbytes};
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_block: got %h expected none", act);
                end else begin
                    e = sb.pop_front();
                    chk("block", {58'b0, act}, {58'b0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        in_data   = 32'h0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_bytes  = 3'd0;
        blk_ready = 1'b1;
        rst       = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'({blk_data, blk_valid, blk_last, blk_pad, blk_nbytes, in_ready}), 128'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_before_first_edge", 128'(in_ready), 128'd0);
        @(posedge clk);
        #1;

        // Message ending on a block boundary.
        expect_blk(64'h0011_2233_4455_6677, !PAD, 1'b0, 4'd8);
        if (PAD) expect_blk(64'h8000_0000_0000_0000, 1'b1, 1'b1, 4'd0);
        send_word(32'h0011_2233, 1'b0, 3'd0);
        send_word(32'h4455_6677, 1'b1, 3'd4);
        drain();

        // Back-to-back short messages, including masking and out-of-range byte counts.
        expect_blk(PAD ? 64'hAABB_CC80_0000_0000 : 64'hAABB_CC00_0000_0000, 1'b1, PAD, 4'd3);
        expect_blk(PAD ? 64'h0102_0304_0580_0000 : 64'h0102_0304_0500_0000, 1'b1, PAD, 4'd5);
        expect_blk(PAD ? 64'hDEAD_BEEF_8000_0000 : 64'hDEAD_BEEF_0000_0000, 1'b1, PAD, 4'd4);
        expect_blk(64'h1122_3344_5566_7788, !PAD, 1'b0, 4'd8);
        if (PAD) expect_blk(64'h8000_0000_0000_0000, 1'b1, 1'b1, 4'd0);
        expect_blk(PAD ? 64'h9999_9999_AB80_0000 : 64'h9999_9999_AB00_0000, 1'b1, PAD, 4'd5);
        send_word(32'hAABB_CCDD, 1'b1, 3'd3);
        send_word(32'h0102_0304, 1'b0, 3'd2);
        send_word(32'h05FF_FFFF, 1'b1, 3'd1);
        send_word(32'hDEAD_BEEF, 1'b1, 3'd0);
        send_word(32'h1122_3344, 1'b0, 3'd0);
        send_word(32'h5566_7788, 1'b1, 3'd7);
        send_word(32'h9999_9999, 1'b0, 3'd0);
        send_word(32'hABCD_EF01, 1'b1, 3'd1);
        drain();

        // Backpressure: block held, input offered but refused.
        blk_ready = 1'b0;
        expect_blk(64'h1111_1111_2222_2222, 1'b0, 1'b0, 4'd8);
        expect_blk(PAD ? 64'hC3C3_8000_0000_0000 : 64'hC3C3_0000_0000_0000, 1'b1, PAD, 4'd2);
        send_word(32'h1111_1111, 1'b0, 3'd0);
        send_word(32'h2222_2222, 1'b0, 3'd0);
        in_data  = 32'hC3C3_C3C3;
        in_last  = 1'b1;
        in_bytes = 3'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_hold", 128'({in_ready, blk_valid, blk_data}),
                128'({1'b0, 1'b1, 64'h1111_1111_2222_2222}));
        end
        @(posedge clk);
        #1 blk_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_one_cycle", 128'({blk_valid, in_ready}), 128'(2'b01));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain();

        // Reset between upper and lower word discards the partial message.
        send_word(32'h1234_5678, 1'b0, 3'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_clear", 128'({blk_data, blk_valid, blk_last, blk_pad, blk_nbytes, in_ready}), 128'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset_release", 128'(in_ready), 128'd0);
        @(posedge clk);
        #1;
        expect_blk(PAD ? 64'hCAFE_BABE_8000_0000 : 64'hCAFE_BABE_0000_0000, 1'b1, PAD, 4'd4);
        send_word(32'hCAFE_BABE, 1'b1, 3'd4);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ascon_pt_packer.md
ASCON_PT_PACKER -- requirements
Module: ascon_pt_packer

Interface
REQ-001 Parameters: none; widths fixed (32-bit input word, 64-bit Ascon-128 rate block).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 in_data  input  32  plaintext word, big-endian, first message byte in [31:24].
REQ-005 in_valid  input  1  in_data/in_last/in_bytes valid.
REQ-006 in_last  input  1  word is the final word of the message.
REQ-007 in_bytes  input  3  valid bytes in a last word, MSB-aligned; 1..4; 0 or >4 treated as 4; ignored when in_last=0.
REQ-008 in_ready  output  1  packer accepts a word this cycle.
REQ-009 blk_data  output  64  rate block (P) to the encrypt core.
REQ-010 blk_valid  output  1  blk_data/blk_last/blk_pad/blk_nbytes valid.
REQ-011 blk_ready  input  1  core consumes the block this cycle.
REQ-012 blk_last  output  1  final block of the message.
REQ-013 blk_pad  output  1  block contains the padding byte.
REQ-014 blk_nbytes  output  4  message bytes in the block, 0..8 (core truncates the last ciphertext block to this count).

Function
REQ-015 Word transfer occurs when in_valid=1 and in_ready=1; block transfer occurs when blk_valid=1 and blk_ready=1.
REQ-016 FSM states: S_HI (await upper word), S_LO (await lower word), S_OUT (present block), S_XPAD (present extra padding block).
REQ-017 in_ready SHALL be 1 in S_HI and S_LO, 0 in S_OUT and S_XPAD; blk_valid SHALL be 1 exactly in S_OUT and S_XPAD.
REQ-018 S_HI, transfer, in_last=0: blk_data[63:32] <= in_data; go S_LO.
REQ-019 S_HI, transfer, in_last=1, b=in_bytes: upper word = b data bytes, byte b = 0x80, remaining bytes 0 (b=4: blk_data[31:24]=0x80); blk_last=1, blk_pad=1, blk_nbytes=b; go S_OUT.
REQ-020 S_LO, transfer, in_last=0: blk_data[31:0] <= in_data, blk_last=0, blk_pad=0, blk_nbytes=8; go S_OUT.
REQ-021 S_LO, transfer, in_last=1, b<4: lower word = b data bytes, 0x80, zeros; blk_last=1, blk_pad=1, blk_nbytes=4+b; go S_OUT.
REQ-022 S_LO, transfer, in_last=1, b=4: full block, blk_last=0, blk_pad=0, blk_nbytes=8; pad_pending set; go S_OUT.
REQ-023 S_OUT, block transfer: go S_XPAD if pad_pending else S_HI; pad_pending cleared on leaving S_OUT.
REQ-024 S_XPAD: blk_data=64'h8000_0000_0000_0000, blk_last=1, blk_pad=1, blk_nbytes=0; on block transfer go S_HI.
REQ-025 Data bytes beyond in_bytes in a last word SHALL be masked to 0 regardless of in_data.
REQ-026 Latency: blk_valid rises the cycle after the completing word transfer; blk outputs SHALL hold stable while blk_valid=1 and blk_ready=0.
REQ-027 Throughput: one 64-bit block per 3 cycles with blk_ready tied high; no word lost or duplicated under any in_valid/blk_ready pattern.
REQ-028 Empty messages are out of scope; every message carries at least one byte.

Reset
REQ-029 RST=1 SHALL immediately force S_HI, blk_data=0, blk_valid=0, blk_last=0, blk_pad=0, blk_nbytes=0, pad_pending=0, in_ready=0.
REQ-030 in_ready SHALL be 0 while RST=1 and 1 from the first CLK edge after release.
REQ-031 Reset mid-message SHALL discard partial words and any pending block; no block is emitted for the aborted message.

Configuration
REQ-032 Macro ASCON_PAD_EN defined: padding per REQ-019/021/022/024.
REQ-033 ASCON_PAD_EN undefined: no 0x80 byte, unused bytes 0, blk_pad held 0, S_XPAD unreachable, REQ-022 case yields blk_last=1, blk_nbytes=8; interface unchanged.

Verification
REQ-034 Words 0x00112233, 0x44556677 (last, bytes=4), blk_ready=1 -> block 0x0011223344556677 last=0 nbytes=8, then 0x8000000000000000 last=1 pad=1 nbytes=0.
REQ-035 Single word 0xAABBCCDD last, bytes=3 -> block 0xAABBCC8000000000, last=1, pad=1, nbytes=3.
REQ-036 Words 0x01020304, 0x05FFFFFF last bytes=1 -> block 0x0102030405800000, last=1, nbytes=5 (masking checked).
REQ-037 blk_ready held 0 for 10 cycles with block pending -> in_ready=0, blk_data stable, no input accepted; release -> transfer in one cycle.
REQ-038 RST asserted between upper and lower word -> outputs zero asynchronously; next message 0xCAFEBABE last bytes=4 -> 0xCAFEBABE80000000.
REQ-039 ASCON_PAD_EN undefined, REQ-034 stimulus -> single block 0x0011223344556677, last=1, pad=0, nbytes=8.
